// File: rtl/serial_tx_uart_pkg.sv
// Shared types and constants for the serial TX path.
// FSM encoding and frame geometry used by the UART transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS    = 8;
  localparam int CLKS_PER_BIT = 434;

endpackage

// File: rtl/serial_tx_uart_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Read data is presented combinationally from the read pointer.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx_uart.sv
// 8N1 UART transmitter fed from a byte FIFO.
// STOP can pop straight into START so queued bytes go out gap-free.
module serial_tx_uart
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = serial_pkg::CLKS_PER_BIT,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          wr_data_in,
  input  logic                wr_en_in,
  output logic                ready_out,
  output logic                tx_out,
  output logic                busy_out,
  output logic [DEPTH_LOG2:0] count_out,
  output logic                overflow_out
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    fifo_dout;
  logic          bit_end;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_en_in),
    .pop   (pop),
    .din   (wr_data_in),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count_out)
  );

  assign ready_out = !full;
  assign busy_out  = (state != IDLE);
  assign bit_end   = (baud == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      baud         <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      tx_out       <= 1'b1;
      overflow_out <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_out  <= tx_n;
      if (wr_en_in && full) begin
        overflow_out <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx_out;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n    = '0;
          bit_idx_n = '0;
          tx_n      = shift[0];
          state_n   = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == BIT_LAST) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_uart.sv
// Directed bench for serial_tx_uart.
// Fast instance (4 clocks/bit, depth 4) plus a 434 clocks/bit instance.
module tb_serial_tx_uart;

  logic       clock;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [2:0] count;
  logic       ovf;

  logic [7:0] s_wr_data;
  logic       s_wr_en;
  logic       s_ready;
  logic       s_tx;
  logic       s_busy;
  logic [2:0] s_count;
  logic       s_ovf;

  int checks;
  int errors;

  serial_tx_uart #(
    .CLKS_PER_BIT (4),
    .DEPTH_LOG2   (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_data_in   (wr_data),
    .wr_en_in     (wr_en),
    .ready_out    (ready),
    .tx_out       (tx),
    .busy_out     (busy),
    .count_out    (count),
    .overflow_out (ovf)
  );

  serial_tx_uart #(
    .CLKS_PER_BIT (434),
    .DEPTH_LOG2   (2)
  ) dut_slow (
    .clock        (clock),
    .reset        (reset),
    .wr_data_in   (s_wr_data),
    .wr_en_in     (s_wr_en),
    .ready_out    (s_ready),
    .tx_out       (s_tx),
    .busy_out     (s_busy),
    .count_out    (s_count),
    .overflow_out (s_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({tx, ready, busy, count, ovf} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_state got %b want 1100000",
               {tx, ready, busy, count, ovf});
    end
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({tx, ready, busy, count} !== 6'b110000) begin
        errors++;
        $display("FAIL idle_%0d got %b want 110000",
                 i, {tx, ready, busy, count});
      end
    end
  endtask

  task automatic test_single();
    logic [9:0] f;
    f = {1'b1, 8'h55, 1'b0};
    wr_data = 8'h55;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_k got cnt=%0d tx=%b want 1 1",
               count, tx);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (tx !== f[i/4] || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_bit%0d got tx=%b busy=%b want %b 1",
                 i, tx, busy, f[i/4]);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end got busy=%b tx=%b want 0 1",
               busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] f;
    f = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
    wr_data = 8'hA3;
    wr_en = 1'b1;
    tick();
    wr_data = 8'h0F;
    for (int i = 0; i < 80; i++) begin
      tick();
      wr_en = 1'b0;
      checks++;
      if (tx !== f[i/4] || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_s%0d got tx=%b busy=%b want %b 1",
                 i, tx, busy, f[i/4]);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_end got busy=%b tx=%b cnt=%0d want 0 1 0",
               busy, tx, count);
    end
  endtask

  task automatic test_burst();
    logic [7:0] b;
    int         bi;
    logic       exp;
    int         n;
    n = 0;
    wr_en = 1'b1;
    for (int w = 1; w <= 6; w++) begin
      wr_data = 8'(w);
      tick();
      checks++;
      if (ready !== (w < 5)) begin
        errors++;
        $display("FAIL burst_ready_w%0d got %b want %b",
                 w, ready, (w < 5));
      end
      checks++;
      if (ovf !== (w == 6)) begin
        errors++;
        $display("FAIL burst_ovf_w%0d got %b want %b",
                 w, ovf, (w == 6));
      end
      if (w >= 2) begin
        b  = 8'((n / 40) + 1);
        bi = (n % 40) / 4;
        exp = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
        checks++;
        if (tx !== exp) begin
          errors++;
          $display("FAIL burst_s%0d got %b want %b", n, tx, exp);
        end
        n++;
      end else begin
        checks++;
        if (tx !== 1'b1) begin
          errors++;
          $display("FAIL burst_k got tx=%b want 1", tx);
        end
      end
    end
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL burst_full got cnt=%0d want 4", count);
    end
    while (n < 200) begin
      tick();
      b  = 8'((n / 40) + 1);
      bi = (n % 40) / 4;
      exp = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      checks++;
      if (tx !== exp) begin
        errors++;
        $display("FAIL burst_s%0d got %b want %b", n, tx, exp);
      end
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || ovf !== 1'b1) begin
        errors++;
        $display("FAIL burst_after%0d got tx=%b busy=%b ovf=%b want 1 0 1",
                 i, tx, busy, ovf);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr_data = 8'hFF;
    wr_en = 1'b1;
    repeat (3) tick();
    wr_en = 1'b0;
    repeat (16) tick();
    checks++;
    if (busy !== 1'b1 || count !== 3'd2) begin
      errors++;
      $display("FAIL mid_pre got busy=%b cnt=%0d want 1 2", busy, count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({tx, busy, count, ovf} !== 6'b100000) begin
      errors++;
      $display("FAIL mid_reset got %b want 100000",
               {tx, busy, count, ovf});
    end
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({tx, busy, count, ovf} !== 6'b100000) begin
        errors++;
        $display("FAIL mid_after%0d got %b want 100000",
                 i, {tx, busy, count, ovf});
      end
    end
  endtask

  task automatic test_slow();
    logic [9:0] f;
    logic [7:0] dec;
    f = {1'b1, 8'h41, 1'b0};
    dec = '0;
    s_wr_data = 8'h41;
    s_wr_en = 1'b1;
    tick();
    s_wr_en = 1'b0;
    for (int i = 0; i < 4340; i++) begin
      tick();
      checks++;
      if (s_tx !== f[i/434]) begin
        errors++;
        $display("FAIL slow_s%0d got %b want %b", i, s_tx, f[i/434]);
      end
      if ((i % 434) == 217 && (i / 434) >= 1 && (i / 434) <= 8) begin
        dec[(i/434)-1] = s_tx;
      end
    end
    checks++;
    if (dec !== 8'h41) begin
      errors++;
      $display("FAIL slow_decode got %h want 41", dec);
    end
    tick();
    checks++;
    if (s_busy !== 1'b0 || s_tx !== 1'b1) begin
      errors++;
      $display("FAIL slow_end got busy=%b tx=%b want 0 1", s_busy, s_tx);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    wr_data   = '0;
    wr_en     = 1'b0;
    s_wr_data = '0;
    s_wr_en   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_burst();
    test_reset_mid();
    test_slow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_uart.md
Name: serial_tx_uart

Overview:
Consumes the byte stream the processor's data memory emits on its serial output port (serial_out / serial_wren_out) and transmits it as 8N1 asynchronous UART frames on a single TX line. Contains an internal FIFO to absorb bursts of stores. Drives the processor's serial_ready_in through ready_out, so software only writes when space exists.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16)

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset
wr_data_in  input  8  byte to transmit (from processor serial_out)
wr_en_in  input  1  write strobe (from processor serial_wren_out)
ready_out  output  1  FIFO not full (to processor serial_ready_in)
tx_out  output  1  UART line; idle high; registered
busy_out  output  1  high while a frame is in progress (state != IDLE)
count_out  output  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2
overflow_out  output  1  sticky flag: a write was attempted while full

Behaviour:
- Reset (reset==0 at a rising edge): FIFO emptied (count_out=0, pointers 0), state=IDLE, tx_out=1, busy_out=0, overflow_out=0, bit/baud counters 0. Reset mid-frame aborts the frame; tx_out is high from that edge on, and no partial byte resumes.
- ready_out = (count_out != 2**DEPTH_LOG2). Combinational from registered count. Reset value 1.
- Write accepted at edge when wr_en_in && ready_out; the byte is stored at the write pointer and the pointer wraps modulo depth.
- Write while full: the byte is dropped, the FIFO is unchanged, and overflow_out is set. It stays set until reset.
- Pop happens only in IDLE with count_out != 0, and also at the end of STOP with count_out != 0. Count update on the same edge: write only +1, pop only -1, both unchanged. A write and pop on the same edge when the FIFO is full cannot occur, because ready_out was low.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1, and the bit period ends when the counter reaches CLKS_PER_BIT-1.
  - IDLE: tx_out=1. If the FIFO is non-empty: pop the byte into the shift register, tx_out<=0, go to START.
  - START: hold tx_out=0 for one bit period, then tx_out<=shift[0] and go to DATA with bit index 0.
  - DATA: hold each bit for one period, LSB first. After bit 7's period, tx_out<=1 and go to STOP.
  - STOP: hold tx_out=1 for one period. At the end of the period:
    - If the FIFO is non-empty, pop, tx_out<=0, and go to START. This gives back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- Latency: byte written at edge k → count_out=1 after edge k → pop and tx_out falls at edge k+1. A frame occupies exactly 10*CLKS_PER_BIT cycles, from the tx_out fall to the first cycle of the next start bit or idle.
- busy_out = (state != IDLE).

Decomposition:
- Shared package serial_pkg: FSM state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), constant DATA_BITS=8, and the default CLKS_PER_BIT.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH_LOG2; push/pop/full/empty/count), instantiated with WIDTH=8. The TX FSM, baud counter, and shift register live in serial_tx_uart.

Test Plan (CLKS_PER_BIT=4, DEPTH_LOG2=2 unless noted):
1. Reset released, no writes for 50 cycles → tx_out=1, ready_out=1, busy_out=0, count_out=0 throughout.
2. Single write 0x55 at edge k → tx_out low from edge k+1. The line then shows 0,1,0,1,0,1,0,1,0,1 in 4-cycle bits (40 cycles). busy_out falls at edge k+41.
3. Write 0xA3, then 0x0F on consecutive cycles → two frames back-to-back with no idle cycle between stop and start. Data bits are LSB first: 1,1,0,0,0,1,0,1, then 1,1,1,1,0,0,0,0.
4. Burst of 6 writes (0x01..0x06) on consecutive cycles, depth 4:
   - First byte is popped at edge k+1.
   - ready_out drops after the 5th write is accepted.
   - 6th write is dropped and overflow_out=1.
   - Transmitted order is 0x01..0x05; 0x06 is never sent.
5. Reset asserted during DATA bit 3 of 0xFF with 2 bytes queued → tx_out=1 from the reset edge, count_out=0, busy_out=0. After release, no frame is sent and overflow_out=0.
6. CLKS_PER_BIT=434, single write 0x41 → each bit lasts 434 cycles and the frame lasts 4340 cycles; the decoded byte equals 0x41.
